// File: rtl/uart_rx_framer.sv
// UART receive framer: start/data/stop framing driven by a mid-bit baud pulse.
// Optional even-parity bit is enabled by defining UART_RX_PARITY_EN.
module uart_rx_framer #(
    parameter int DATA_BITS = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rxd,
    input  logic                 clk_bps,
    output logic                 bps_start,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 frame_err,
    output logic                 busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_RX_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } state_t;

    localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

    state_t               r_state;
    logic                 r_sync1;
    logic                 r_sync2;
    logic                 r_prev;
    logic [DATA_BITS-1:0] r_shift;
    logic [2:0]           r_bit_cnt;
    logic                 r_par_err;

    logic w_rxd_s;
    logic w_fall;

    assign w_rxd_s = r_sync2;
    assign w_fall  = r_prev & ~r_sync2;
    assign busy    = bps_start;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_sync1   <= 1'b1;
            r_sync2   <= 1'b1;
            r_prev    <= 1'b1;
            r_shift   <= '0;
            r_bit_cnt <= '0;
            r_par_err <= 1'b0;
            bps_start <= 1'b0;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            r_sync1   <= rxd;
            r_sync2   <= r_sync1;
            r_prev    <= r_sync2;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_fall) begin
                        r_state   <= S_START;
                        bps_start <= 1'b1;
                    end
                end
                S_START: begin
                    if (clk_bps) begin
                        r_par_err <= 1'b0;
                        r_bit_cnt <= '0;
                        if (!w_rxd_s) begin
                            r_state <= S_DATA;
                        end else begin
                            // glitch on the line: abandon quietly
                            r_state   <= S_IDLE;
                            bps_start <= 1'b0;
                        end
                    end
                end
                S_DATA: begin
                    if (clk_bps) begin
                        r_shift <= {w_rxd_s, r_shift[DATA_BITS-1:1]};
                        if (r_bit_cnt == LAST_BIT) begin
                            r_bit_cnt <= '0;
`ifdef UART_RX_PARITY_EN
                            r_state   <= S_PARITY;
`else
                            r_state   <= S_STOP;
`endif
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 3'd1;
                        end
                    end
                end
`ifdef UART_RX_PARITY_EN
                S_PARITY: begin
                    if (clk_bps) begin
                        r_par_err <= ^{r_shift, w_rxd_s};
                        r_state   <= S_STOP;
                    end
                end
`endif
                S_STOP: begin
                    if (clk_bps) begin
                        if (w_rxd_s && !r_par_err) begin
                            rx_data  <= r_shift;
                            rx_valid <= 1'b1;
                        end else begin
                            frame_err <= 1'b1;
                        end
                        r_state   <= S_IDLE;
                        bps_start <= 1'b0;
                    end
                end
                default: begin
                    r_state   <= S_IDLE;
                    bps_start <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/uart_rx_framer.md
UART_RX_FRAMER -- requirements
Module: uart_rx_framer

Interface
REQ-001 Parameter DATA_BITS, default 8, number of data bits per frame (5..8), sent LSB first.
REQ-002 clk  input  1  system clock, 50 MHz.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 rxd  input  1  asynchronous UART line, idle high.
REQ-005 clk_bps  input  1  one-cycle pulse from the baud generator at the middle of each bit; the generator counts only while bps_start is high.
REQ-006 bps_start  output  1  high while a frame is being received; enables the baud generator.
REQ-007 rx_data  output  DATA_BITS  last good received byte, held until the next good frame.
REQ-008 rx_valid  output  1  one-cycle pulse when rx_data updates.
REQ-009 frame_err  output  1  one-cycle pulse on bad stop bit (or bad parity when enabled).
REQ-010 busy  output  1  equals bps_start.

Function
REQ-011 rxd shall pass through a 2-flop synchronizer; all logic shall use the synchronized value rxd_s.
REQ-012 A falling edge is rxd_s previous=1, current=0, detected in IDLE only.
REQ-013 FSM states: IDLE, START, DATA, PARITY (only with UART_RX_PARITY_EN), STOP.
REQ-014 IDLE to START on falling edge; bps_start shall go high on the next clk edge.
REQ-015 In START, on clk_bps: rxd_s=0 goes to DATA; rxd_s=1 is a false start and returns to IDLE with bps_start low the next cycle, with no pulse output.
REQ-016 In DATA, each clk_bps shall shift rxd_s into a shift register, LSB first; a 3-bit counter shall track bits.
REQ-017 After DATA_BITS samples, DATA goes to PARITY (if enabled) or to STOP.
REQ-018 In STOP, on clk_bps with rxd_s=1 and no parity error: rx_data is loaded from the shift register and rx_valid pulses in the same cycle.
REQ-019 In STOP, on clk_bps with rxd_s=0 or a parity error: frame_err pulses, rx_data is unchanged and rx_valid stays low.
REQ-020 On any STOP sample, return to IDLE and drop bps_start in that same transition.
REQ-021 A new falling edge is accepted starting in the first cycle after the return to IDLE.
REQ-022 rx_valid and frame_err shall never be high in the same cycle.
REQ-023 clk_bps shall be ignored in IDLE.
REQ-024 rxd edges between clk_bps pulses shall have no effect outside IDLE.
REQ-025 No output handshake: a new good frame overwrites rx_data.

Reset
REQ-026 With rst high at a clk edge: the FSM goes to IDLE; bps_start, rx_valid, frame_err and busy go to 0; rx_data, the shift register and the bit counter go to 0; both synchronizer flops go to 1.
REQ-027 Reset mid-frame shall abort the frame with no pulse output.
REQ-028 After reset, the next falling edge starts a fresh frame.

Configuration
REQ-029 Macro UART_RX_PARITY_EN.
  - Defined: the PARITY state samples one bit after the data bits; even parity is required (XOR of the data bits and the parity bit = 0); a mismatch is reported as frame_err at the stop sample.
  - Undefined: there is no PARITY state or logic, and the frame is start + DATA_BITS + stop.

Verification
REQ-030 Setup: 115200 baud, 434-cycle bit period, DATA_BITS=8, macro off. Send 0xA5 with stop=1 -> rx_data=0xA5, one rx_valid pulse about 9.5 bit periods after the start edge, bps_start low the same cycle.
REQ-031 Drive rxd low for 100 cycles, then high -> bps_start rises, then falls after the first clk_bps; no rx_valid and no frame_err.
REQ-032 Send 0x3C with stop=0 -> one frame_err pulse, no rx_valid, rx_data keeps its previous value.
REQ-033 Assert rst during bit 4 of 0x81 -> all outputs 0 next cycle; then send 0x81 -> rx_data=0x81 with rx_valid.
REQ-034 Macro on. Send 0x07 with parity=1 -> rx_valid, rx_data=0x07. Send 0x07 with parity=0 -> frame_err only.
REQ-035 Send 0x55 and 0xAA back-to-back, with the second start bit immediately after the first stop bit -> two rx_valid pulses with 0x55 then 0xAA.
